// File: rtl/pristis_sync_pkg.sv
// Shared constants and helpers for the Pristis DAC measurement-gate sequencer.
package pristis_sync_pkg;

  localparam int NUM_PAIRS = 4;
  localparam int unsigned ADDR_PERIOD = 'h00;
  localparam int unsigned ADDR_MASK   = 'h04;

  typedef logic [NUM_PAIRS-1:0] pair_vec_t;

  localparam pair_vec_t MASK_RESET = 4'hF;

  function automatic pair_vec_t slot_onehot(input logic [1:0] slot);
    pair_vec_t v;
    v       = '0;
    v[slot] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/pristis_sync_sequencer.sv
// Rotates a gate through the four channel pairs, holding each for PERIOD cycles.
module pristis_sync_sequencer
  import pristis_sync_pkg::*;
#(
  parameter int PERIOD_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic                    load_run,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  pair_vec_t               mask,
  output pair_vec_t               gate
);

  logic                    run;
  logic [1:0]              slot;
  logic [PERIOD_WIDTH-1:0] cnt;
  logic [PERIOD_WIDTH-1:0] cnt_last;

  assign cnt_last = period - PERIOD_WIDTH'(1);

  // A load restarts the rotation from pair 0 with a one-cycle low gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run  <= 1'b0;
      slot <= 2'd0;
      cnt  <= '0;
      gate <= '0;
    end else if (load) begin
      run  <= load_run;
      slot <= 2'd0;
      cnt  <= '0;
      gate <= '0;
    end else if (run) begin
      gate <= slot_onehot(slot) & mask;
      if (cnt == cnt_last) begin
        cnt  <= '0;
        slot <= slot + 2'd1;
      end else begin
        cnt <= cnt + PERIOD_WIDTH'(1);
      end
    end else begin
      gate <= '0;
    end
  end

endmodule

// File: rtl/pristis_sync_top.sv
// Write-port decode and PERIOD/MASK registers for the Pristis measurement-gate sequencer.
module pristis_sync_top
  import pristis_sync_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int PERIOD_WIDTH = 16
) (
  input  logic                  s_axi_aclk,
  input  logic                  dac_reset_n,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  input  logic                  s_axi_wvalid,
  input  logic [31:0]           s_axi_wdata,
  output logic                  meascnt_0_1,
  output logic                  meascnt_2_3,
  output logic                  meascnt_4_5,
  output logic                  meascnt_6_7
);

  localparam logic [ADDR_WIDTH-1:0] PERIOD_ADDR = ADDR_WIDTH'(ADDR_PERIOD);
  localparam logic [ADDR_WIDTH-1:0] MASK_ADDR   = ADDR_WIDTH'(ADDR_MASK);

  logic                    wr_en;
  logic                    hit_period;
  logic                    hit_mask;
  logic                    period_load;
  logic [PERIOD_WIDTH-1:0] new_period;
  logic [PERIOD_WIDTH-1:0] period;
  pair_vec_t               mask;
  pair_vec_t               gate;
  logic                    unused_bits;

  assign wr_en       = s_axi_awvalid & s_axi_wvalid;
  assign hit_period  = wr_en && (s_axi_awaddr[ADDR_WIDTH-1:2] == PERIOD_ADDR[ADDR_WIDTH-1:2]);
  assign hit_mask    = wr_en && (s_axi_awaddr[ADDR_WIDTH-1:2] == MASK_ADDR[ADDR_WIDTH-1:2]);
  assign new_period  = s_axi_wdata[PERIOD_WIDTH-1:0];
  // Rewriting the current value must not restart the rotation.
  assign period_load = hit_period && (new_period != period);
  assign unused_bits = ^{s_axi_wdata[31:PERIOD_WIDTH], s_axi_awaddr[1:0]};

  always_ff @(posedge s_axi_aclk or negedge dac_reset_n) begin
    if (!dac_reset_n) begin
      period <= '0;
      mask   <= MASK_RESET;
    end else begin
      if (period_load) begin
        period <= new_period;
      end
      if (hit_mask) begin
        mask <= s_axi_wdata[NUM_PAIRS-1:0];
      end
    end
  end

  pristis_sync_sequencer #(
    .PERIOD_WIDTH(PERIOD_WIDTH)
  ) u_sequencer (
    .clk      (s_axi_aclk),
    .rst_n    (dac_reset_n),
    .load     (period_load),
    .load_run (new_period != '0),
    .period   (period),
    .mask     (mask),
    .gate     (gate)
  );

  assign meascnt_0_1 = gate[0];
  assign meascnt_2_3 = gate[1];
  assign meascnt_4_5 = gate[2];
  assign meascnt_6_7 = gate[3];

endmodule

// File: tb/tb_pristis_sync_top.sv
// Self-checking bench for pristis_sync_top: timeline model plus directed literal checks.
module tb_pristis_sync_top;

  localparam int AW = 16;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          awvalid = 1'b0;
  logic          wvalid = 1'b0;
  logic [AW-1:0] awaddr = '0;
  logic [31:0]   wdata = '0;
  logic          m01, m23, m45, m67;
  logic [3:0]    outs;

  int asserts = 0;
  int failures = 0;

  assign outs = {m67, m45, m23, m01};

  always #5 clk = ~clk;

  pristis_sync_top #(
    .ADDR_WIDTH  (AW),
    .PERIOD_WIDTH(PW)
  ) dut (
    .s_axi_aclk   (clk),
    .dac_reset_n  (rst_n),
    .s_axi_awaddr (awaddr),
    .s_axi_awvalid(awvalid),
    .s_axi_wvalid (wvalid),
    .s_axi_wdata  (wdata),
    .meascnt_0_1  (m01),
    .meascnt_2_3  (m23),
    .meascnt_4_5  (m45),
    .meascnt_6_7  (m67)
  );

  // Model: the gate after edge k of a run is pair ((k-1)/N) mod 4, filtered by the mask in force.
  int         m_period = 0;
  logic [3:0] m_mask = 4'hF;
  bit         m_run = 1'b0;
  int         m_k = 0;
  logic [3:0] exp_outs = 4'h0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_period = 0;
      m_mask   = 4'hF;
      m_run    = 1'b0;
      m_k      = 0;
      exp_outs = 4'h0;
    end else begin
      if (awvalid && wvalid && awaddr[AW-1:2] == 0 && int'(wdata[PW-1:0]) != m_period) begin
        m_period = int'(wdata[PW-1:0]);
        m_run    = (m_period != 0);
        m_k      = 0;
        exp_outs = 4'h0;
      end else if (m_run) begin
        m_k      = m_k + 1;
        exp_outs = (4'b0001 << (((m_k - 1) / m_period) % 4)) & m_mask;
      end else begin
        exp_outs = 4'h0;
      end
      if (awvalid && wvalid && awaddr[AW-1:2] == 1) begin
        m_mask = wdata[3:0];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [3:0] expected);
    asserts++;
    if (outs !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, outs, expected, $time);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int expected);
    asserts++;
    if (got != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic aw, input logic w,
                               input logic [AW-1:0] addr, input logic [31:0] data);
    awvalid = aw;
    wvalid  = w;
    awaddr  = addr;
    wdata   = data;
  endtask

  task automatic countHigh(input int cycles, output int c01, output int c23,
                           output int c45, output int c67);
    c01 = 0; c23 = 0; c45 = 0; c67 = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      c01 += int'(m01);
      c23 += int'(m23);
      c45 += int'(m45);
      c67 += int'(m67);
    end
  endtask

  // Every cycle: DUT against model, plus one-hot exclusivity.
  initial forever begin
    @(negedge clk);
    checkOutput("model", exp_outs);
    asserts++;
    if ($countones(outs) > 1) begin
      failures++;
      $display("[TB] FAIL exclusive: got %b required at most one high", outs);
    end
  end

  initial begin
    logic [3:0] exp2 [10];
    logic [3:0] exp3 [11];
    int c01, c23, c45, c67;
    int n;

    exp2 = '{4'h0, 4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1};
    exp3 = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h4, 4'h4, 4'h4, 4'h8};

    $display("[TB] reset and idle");
    applyStimulus(1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    checkOutput("reset_state", 4'h0);
    rst_n = 1'b1;
    countHigh(100, c01, c23, c45, c67);
    checkCount("idle_high_cycles", c01 + c23 + c45 + c67, 0);

    $display("[TB] hold PERIOD=0");
    applyStimulus(1'b1, 1'b1, 16'h0000, 32'd0);
    countHigh(50, c01, c23, c45, c67);
    checkCount("write0_high_cycles", c01 + c23 + c45 + c67, 0);

    $display("[TB] hold PERIOD=2");
    applyStimulus(1'b1, 1'b1, 16'h0000, 32'd2);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput($sformatf("write2_edge%0d", k), exp2[k]);
    end
    countHigh(16, c01, c23, c45, c67);
    checkCount("write2_rewrite_0_1", c01, 4);
    checkCount("write2_rewrite_6_7", c67, 4);

    $display("[TB] change PERIOD to 3 mid-slot");
    n = 0;
    while (!m23 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkCount("wait_pair_2_3", int'(m23), 1);
    applyStimulus(1'b1, 1'b1, 16'h0000, 32'd3);
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (k == 0) applyStimulus(1'b0, 1'b0, '0, '0);
      checkOutput($sformatf("midslot_edge%0d", k), exp3[k]);
    end

    $display("[TB] awvalid-only write");
    applyStimulus(1'b1, 1'b0, 16'h0000, 32'd7);
    repeat (5) @(negedge clk);
    applyStimulus(1'b0, 1'b0, '0, '0);
    countHigh(12, c01, c23, c45, c67);
    checkCount("awonly_0_1", c01, 3);

    $display("[TB] mask 0101 with PERIOD=2");
    applyStimulus(1'b1, 1'b1, 16'h0000, 32'd2);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 16'h0004, 32'h5);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, '0, '0);
    repeat (8) @(negedge clk);
    countHigh(16, c01, c23, c45, c67);
    checkCount("mask_0_1", c01, 4);
    checkCount("mask_2_3", c23, 0);
    checkCount("mask_4_5", c45, 4);
    checkCount("mask_6_7", c67, 0);

    $display("[TB] reset mid-run");
    n = 0;
    while (outs == 4'h0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkCount("wait_any_gate", int'(outs != 4'h0), 1);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset", 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    countHigh(30, c01, c23, c45, c67);
    checkCount("post_reset_idle", c01 + c23 + c45 + c67, 0);
    applyStimulus(1'b1, 1'b1, 16'h0000, 32'd2);
    @(negedge clk);
    checkOutput("restart_edge0", 4'h0);
    applyStimulus(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("restart_edge1", 4'h1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("restart_edge3", 4'h2);
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
